ica_grad_accum: RTL and testbench

ICA_GRAD_ACCUM -- requirements
Module: ica_grad_accum

---
 rtl/ica_grad_accum.sv | 155 +++++++++++++++
 tb/tb_ica_grad_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ica_grad_accum.sv
// FastICA expectation accumulator: forms E{x*g(y)} and E{g'(y)} over one
// N_SAMP-sample frame for 3 components, fed by the per-sample tanh stage.
// Ports:
//   clk, rst (async active-low), flush (sync frame abort, ignored in OUT)
//   in_valid/in_ready, in_x[0:2] (whitened sample), in_g[0:2] (Q1.14 tanh)
//   out_valid/out_ready, exg[i][k] = mean x[k]*g[i], egd[i] = mean 1-g[i]^2
module ica_grad_accum #(
  parameter int unsigned N_SAMP = 64,
  parameter int unsigned LOG2_N = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x [0:2],
  input  logic signed [15:0] in_g [0:2],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] exg [0:2][0:2],
  output logic        [15:0] egd [0:2]
);

  localparam int unsigned NC     = 3;
  localparam int unsigned PW     = 32;
  localparam int unsigned DW     = 17;
  localparam int unsigned AW     = 38;
  localparam int unsigned DAW    = 23;
  localparam int unsigned LAT_W  = 3;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [LOG2_N-1:0]      r_cnt;
  logic                   r_s1_valid;
  logic [LAT_W-1:0]       r_lat;
  logic signed [PW-1:0]   r_prod [0:NC-1][0:NC-1];
  logic signed [DW-1:0]   r_d    [0:NC-1];
  logic signed [AW-1:0]   r_acc  [0:NC-1][0:NC-1];
  logic signed [DAW-1:0]  r_dacc [0:NC-1];

  logic signed [PW-1:0]   w_prod [0:NC-1][0:NC-1];
  logic signed [PW-1:0]   w_gsq  [0:NC-1];
  logic signed [DW-1:0]   w_d    [0:NC-1];
  logic                   w_accept;
  logic                   w_last;
  logic                   w_flush_acc;
  logic                   w_out_hs;

  assign w_accept    = in_valid & in_ready;
  assign w_last      = w_accept && (r_cnt == LOG2_N'(N_SAMP - 1));
  assign w_flush_acc = flush && (r_state == ST_ACC);
  assign w_out_hs    = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin : p_state
    if (!rst) r_state <= ST_ACC;
    else      r_state <= w_state_nxt;
  end

  // Next state and input handshake
  always_comb begin : p_fsm
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = !flush;
        if (w_last) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (w_out_hs) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Stage-1 arithmetic: cross products and 1 - g^2 in Q1.14
  always_comb begin : p_stage1_math
    for (int i = 0; i < NC; i++) begin
      for (int k = 0; k < NC; k++) begin
        w_prod[i][k] = PW'(in_x[k]) * PW'(in_g[i]);
      end
      w_gsq[i] = PW'(in_g[i]) * PW'(in_g[i]);
      w_d[i]   = DW'(32'sd16384 - (w_gsq[i] >>> 14));
    end
  end

  // Pipeline, accumulators, beat counter and result registers
  always_ff @(posedge clk or negedge rst) begin : p_datapath
    if (!rst) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_lat      <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < NC; i++) begin
        for (int k = 0; k < NC; k++) begin
          r_prod[i][k] <= '0;
          r_acc[i][k]  <= '0;
          exg[i][k]    <= '0;
        end
        r_d[i]    <= '0;
        r_dacc[i] <= '0;
        egd[i]    <= '0;
      end
    end else begin
      // r_lat tracks the last beat: stage 1, stage 2 add, then result load
      r_lat <= {r_lat[LAT_W-2:0], w_last};

      if (w_flush_acc) begin
        r_cnt      <= '0;
        r_s1_valid <= 1'b0;
        for (int i = 0; i < NC; i++) begin
          for (int k = 0; k < NC; k++) r_acc[i][k] <= '0;
          r_dacc[i] <= '0;
        end
      end else begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          for (int i = 0; i < NC; i++) begin
            for (int k = 0; k < NC; k++) r_prod[i][k] <= w_prod[i][k];
            r_d[i] <= w_d[i];
          end
        end
        if (w_out_hs) begin
          r_cnt <= '0;
          for (int i = 0; i < NC; i++) begin
            for (int k = 0; k < NC; k++) r_acc[i][k] <= '0;
            r_dacc[i] <= '0;
          end
        end else begin
          if (w_accept) r_cnt <= r_cnt + LOG2_N'(1);
          if (r_s1_valid) begin
            for (int i = 0; i < NC; i++) begin
              for (int k = 0; k < NC; k++) r_acc[i][k] <= r_acc[i][k] + AW'(r_prod[i][k]);
              r_dacc[i] <= r_dacc[i] + DAW'(r_d[i]);
            end
          end
        end
      end

      if (r_lat[LAT_W-1]) begin
        out_valid <= 1'b1;
        for (int i = 0; i < NC; i++) begin
          for (int k = 0; k < NC; k++) exg[i][k] <= PW'(r_acc[i][k] >>> LOG2_N);
          egd[i] <= 16'(r_dacc[i] >> LOG2_N);
        end
      end else if (w_out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ica_grad_accum.sv
// Directed bench for ica_grad_accum: reset, two hand-computed frames,
// output backpressure, mid-frame reset, flush, and random frames checked
// against an arithmetic reference model.
module tb_ica_grad_accum;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_x [0:2];
  logic signed [15:0] in_g [0:2];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] exg [0:2][0:2];
  logic        [15:0] egd [0:2];

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] exp_exg [0:2][0:2];
  logic        [15:0] exp_egd [0:2];
  longint             m_acc   [0:2][0:2];
  longint             m_dacc  [0:2];

  always #5 clk = ~clk;

  ica_grad_accum #(.N_SAMP(64), .LOG2_N(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_g     (in_g),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .exg      (exg),
    .egd      (egd)
  );

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s_exg[%0d][%0d]", tag, i, k), exg[i][k], exp_exg[i][k]);
      chk($sformatf("%s_egd[%0d]", tag, i), egd[i], exp_egd[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) m_acc[i][k] = 0;
      m_dacc[i] = 0;
    end
  endtask

  task automatic exp_from_model();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) exp_exg[i][k] = 32'(m_acc[i][k] >>> 6);
      exp_egd[i] = 16'(m_dacc[i] >> 6);
    end
  endtask

  task automatic exp_030();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) exp_exg[i][k] = 32'sd1638400;
      exp_egd[i] = 16'd0;
    end
  endtask

  task automatic exp_031();
    exp_exg[0][0] = 0;      exp_exg[0][1] = 0;      exp_exg[0][2] = 0;
    exp_exg[1][0] = 16384;  exp_exg[1][1] = -32768; exp_exg[1][2] = -49152;
    exp_exg[2][0] = -8192;  exp_exg[2][1] = 16384;  exp_exg[2][2] = 24576;
    exp_egd[0] = 16'd16384; exp_egd[1] = 16'd0;     exp_egd[2] = 16'd12288;
  endtask

  // Present one beat (optionally after a random idle gap) and wait for accept
  task automatic send_beat(input logic signed [15:0] x0, x1, x2, g0, g1, g2, input bit gaps);
    int n;
    int guard;
    longint xs [0:2];
    longint gs [0:2];
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
          in_x[j] = 16'($urandom);
          in_g[j] = 16'($urandom);
        end
        step();
      end
    end
    in_x[0] = x0; in_x[1] = x1; in_x[2] = x2;
    in_g[0] = g0; in_g[1] = g1; in_g[2] = g2;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("in_ready_for_beat", in_ready, 1);
    chk("no_early_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    xs[0] = x0; xs[1] = x1; xs[2] = x2;
    gs[0] = g0; gs[1] = g1; gs[2] = g2;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) m_acc[i][k] += xs[k] * gs[i];
      m_dacc[i] += 16384 - ((gs[i] * gs[i]) >>> 14);
    end
  endtask

  task automatic beats_030(input int n, input bit gaps);
    repeat (n) send_beat(16'sd100, 16'sd100, 16'sd100, 16'sd16384, 16'sd16384, 16'sd16384, gaps);
  endtask

  task automatic beats_031(input int n, input bit gaps);
    repeat (n) send_beat(-16'sd1, 16'sd2, 16'sd3, 16'sd0, -16'sd16384, 16'sd8192, gaps);
  endtask

  // Called right after the edge accepting the final beat
  task automatic finish_frame(input string tag, input int hold, input bit flush_in_out);
    chk({tag, "_in_ready_low_out"}, in_ready, 0);
    chk({tag, "_lat0"}, out_valid, 0);
    step();
    chk({tag, "_lat1"}, out_valid, 0);
    step();
    chk({tag, "_lat2"}, out_valid, 0);
    step();
    chk({tag, "_lat3"}, out_valid, 1);
    check_out(tag);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      flush = flush_in_out && (h == 0);
      step();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      check_out({tag, "_hold"});
    end
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin : stim
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_x[j] = '0;
      in_g[j] = '0;
    end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) exp_exg[i][k] = 0;
      exp_egd[i] = 0;
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    check_out("rst");
    rst = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Constant frame, g = +1.0 exactly
    clear_model();
    beats_030(64, 1'b0);
    exp_030();
    finish_frame("f030", 0, 1'b0);

    // Mixed-sign frame, 10-cycle backpressure with a flush while in OUT
    clear_model();
    beats_031(64, 1'b0);
    exp_031();
    finish_frame("f031", 10, 1'b1);

    // Mid-frame reset discards partial sums
    beats_030(30, 1'b0);
    rst = 1'b0;
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst = 1'b1;
    step();
    clear_model();
    beats_031(64, 1'b0);
    exp_031();
    finish_frame("after_rst", 0, 1'b0);

    // Flush after 40 beats; a beat offered during flush must be refused
    beats_030(40, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    clear_model();
    beats_030(64, 1'b1);
    exp_030();
    finish_frame("after_flush", 0, 1'b0);

    // Random frames with gaps and backpressure against the reference model
    for (int f = 0; f < 2; f++) begin
      clear_model();
      for (int b = 0; b < 64; b++) begin
        send_beat(16'($urandom), 16'($urandom), 16'($urandom),
                  16'(int'($urandom_range(0, 32768)) - 16384),
                  16'(int'($urandom_range(0, 32768)) - 16384),
                  16'(int'($urandom_range(0, 32768)) - 16384), 1'b1);
      end
      exp_from_model();
      finish_frame($sformatf("rand%0d", f), int'($urandom_range(0, 5)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
